// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480 VGA timing constants, error indices and lock states
//
// Purpose: timing values shared by the display controller and the receive
// monitor, derived sync positions, sticky error bit positions and the lock
// state machine encoding.
// Ports: none (package).
package vga_timing_pkg;

  localparam int H_DISPLAY   = 640;
  localparam int H_FRONT     = 16;
  localparam int H_SYNC      = 96;
  localparam int H_TOTAL     = 800;
  localparam int V_DISPLAY   = 480;
  localparam int V_FRONT     = 10;
  localparam int V_SYNC      = 2;
  localparam int V_TOTAL     = 525;
  localparam int LOCK_FRAMES = 2;

  // Sync pulse positions in recovered coordinates
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Sticky error bit positions
  localparam int ERR_LINE   = 0;
  localparam int ERR_HSYNC  = 1;
  localparam int ERR_VPOS   = 2;
  localparam int ERR_VWIDTH = 3;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - registered 1-bit sync input with rise/fall detection
//
// Purpose: registers a sync line once and keeps the previous sample so that
// rising and falling edges of the registered stream can be detected.
// Ports:
//   clk  in  pixel clock
//   rst  in  asynchronous reset, active-high
//   d    in  raw sync input
//   rise out high while the current registered sample is a 0->1 transition
//   fall out high while the current registered sample is a 1->0 transition
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic cur;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= d;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;
  assign fall = ~cur & prev;

endmodule

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive monitor: coordinate recovery, timing checks, lock, probe
//
// Purpose: samples hsync/vsync/RGB, rebuilds pixel coordinates, checks line
// and frame timing, runs the SEARCH/MEASURE/LOCKED lock machine and captures
// the colour at a programmable probe pixel.
// Ports:
//   clk, rst                      pixel clock, async active-high reset
//   hsync_in, vsync_in            sync inputs, active-high pulses
//   red_in, green_in, blue_in     3-bit colour lanes
//   probe_x, probe_y              probe coordinate, latched at each vsync rise
//   clr_err                       clears sticky error bits
//   pix_x, pix_y, pix_rgb         recovered coordinate and colour (2 clocks after input)
//   pix_valid                     locked and pixel inside the active area
//   locked, lost_lock             lock status and one-cycle loss pulse
//   err                           sticky timing errors
//   frame_count                   vsync rises seen while locked
//   probe_rgb, probe_valid        probe capture and update pulse
module vga_rx_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  red_in,
  input  logic [2:0]  green_in,
  input  logic [2:0]  blue_in,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  input  logic        clr_err,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [8:0]  pix_rgb,
  output logic        pix_valid,
  output logic        locked,
  output logic        lost_lock,
  output logic [3:0]  err,
  output logic [15:0] frame_count,
  output logic [8:0]  probe_rgb,
  output logic        probe_valid
);

  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic [8:0]  rgb1, rgb2;
  logic [9:0]  rx_h, rx_v;
  logic [9:0]  h_free, v_free;
  logic [9:0]  probe_x_l, probe_y_l;
  logic [3:0]  err_now;
  logic [3:0]  good_cnt;
  logic        any_err;
  logic        in_active;
  lock_state_t state;

  vga_sync_edge u_hsync (
    .clk (clk),
    .rst (rst),
    .d   (hsync_in),
    .rise(hs_rise),
    .fall(hs_fall)
  );

  vga_sync_edge u_vsync (
    .clk (clk),
    .rst (rst),
    .d   (vsync_in),
    .rise(vs_rise),
    .fall(vs_fall)
  );

  // Colour follows the sync path: rgb1 aligns with the edge detectors,
  // rgb2 aligns with rx_h/rx_v.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb1 <= '0;
      rgb2 <= '0;
    end else begin
      rgb1 <= {red_in, green_in, blue_in};
      rgb2 <= rgb1;
    end
  end

  // Coordinate the current stage-1 sample would get without any reload
  always_comb begin
    h_free = (rx_h == H_LAST) ? 10'd0 : rx_h + 10'd1;
    v_free = rx_v;
    if (rx_h == H_LAST)
      v_free = (rx_v == V_LAST) ? 10'd0 : rx_v + 10'd1;
  end

  always_comb begin
    err_now = '0;
    if (state != SEARCH) begin
      err_now[ERR_LINE]   = hs_rise && (h_free != HS_START);
      err_now[ERR_HSYNC]  = hs_fall && (h_free != HS_END);
      err_now[ERR_VPOS]   = vs_rise && ((h_free != 10'd0) || (v_free != VS_START));
      err_now[ERR_VWIDTH] = vs_fall && ((h_free != 10'd0) || (v_free != VS_END));
    end
  end

  assign any_err   = |err_now;
  assign in_active = (rx_h < H_ACT) && (rx_v < V_ACT);

  // Counters keep running through errors; sync edges realign them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_h      <= '0;
      rx_v      <= '0;
      probe_x_l <= '0;
      probe_y_l <= '0;
    end else begin
      if (vs_rise) begin
        rx_h      <= 10'd0;
        rx_v      <= VS_START;
        probe_x_l <= probe_x;
        probe_y_l <= probe_y;
      end else if (hs_rise) begin
        rx_h <= HS_START;
      end else begin
        rx_h <= h_free;
        rx_v <= v_free;
      end
    end
  end

  // A new error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= '0;
    else     err <= (clr_err ? 4'd0 : err) | err_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      good_cnt    <= '0;
      locked      <= 1'b0;
      lost_lock   <= 1'b0;
      frame_count <= '0;
    end else begin
      lost_lock <= 1'b0;
      case (state)
        SEARCH: begin
          if (vs_rise) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (any_err) begin
            state <= SEARCH;
          end else if (vs_rise) begin
            if (good_cnt + 4'd1 == LOCK_N) begin
              state       <= LOCKED;
              locked      <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end
            good_cnt <= good_cnt + 4'd1;
          end
        end
        LOCKED: begin
          if (any_err) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            lost_lock <= 1'b1;
          end else if (vs_rise) begin
            frame_count <= frame_count + 16'd1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      pix_valid   <= 1'b0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      pix_x       <= rx_h;
      pix_y       <= rx_v;
      pix_rgb     <= rgb2;
      pix_valid   <= locked && in_active;
      // in_active keeps an out-of-area probe from ever firing
      probe_valid <= locked && in_active && (rx_h == probe_x_l) && (rx_v == probe_y_l);
      if (locked && in_active && (rx_h == probe_x_l) && (rx_v == probe_y_l))
        probe_rgb <= rgb2;
    end
  end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
Receiving end of the 640x480 VGA link driven by the display path. It samples hsync, vsync and the 3-bit RGB lanes on the pixel clock and rebuilds the pixel coordinates. It checks line and frame timing against the expected values, runs a lock state machine, and captures the RGB value at a programmable probe pixel. It is used as an on-chip self-check of the video path and as the scoreboard front-end in the game-level bench.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, front porch (sync rises at H_DISPLAY+H_FRONT = 656)
H_SYNC, 96, hsync pulse width in clocks
H_TOTAL, 800, clocks per line
V_DISPLAY, 480, active lines
V_FRONT, 10, vertical front porch (vsync rises at line 490)
V_SYNC, 2, vsync pulse width in lines
V_TOTAL, 525, lines per frame
LOCK_FRAMES, 2, consecutive clean frames needed to lock (range 1..15)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
hsync_in  in  1  horizontal sync, active-high during the pulse
vsync_in  in  1  vertical sync, active-high during the pulse
red_in, green_in, blue_in  in  3 each  pixel colour
probe_x, probe_y  in  10 each  probe coordinate, sampled at every vsync rise
clr_err  in  1  clears the sticky error bits
pix_x, pix_y  out  10 each  recovered coordinate of the pixel on pix_rgb
pix_rgb  out  9  {r,g,b} of that pixel
pix_valid  out  1  locked and pixel inside the active area
locked  out  1  lock state machine is in LOCKED
lost_lock  out  1  one-cycle pulse on LOCKED -> SEARCH
err  out  4  sticky bits: [0] line length, [1] hsync width, [2] frame/vsync position, [3] vsync width
frame_count  out  16  number of vsync rises seen while locked; wraps
probe_rgb  out  9  RGB captured at the probe pixel
probe_valid  out  1  one-cycle pulse when probe_rgb updates

Behaviour:
- Reset, asynchronous: all outputs 0; internal counters 0; state SEARCH.
- Stage 1: register all inputs; also keep the previous hsync and vsync samples for edge detection.
- Coordinate counters rx_h and rx_v, each 10 bits:
  - rx_h counts 0..H_TOTAL-1 and wraps to 0.
  - rx_v increments only when rx_h wraps, over 0..V_TOTAL-1.
- Reload rules, applied to the stage-1 sample:
  - hsync rise: rx_h := H_DISPLAY+H_FRONT (656).
  - vsync rise: rx_v := V_DISPLAY+V_FRONT (490) and rx_h := 0.
  - Both rise on the same sample: vsync wins.
- Checks, active in MEASURE and LOCKED only:
  - err[0]: at an hsync rise, the free-running rx_h is not already 656.
  - err[1]: at an hsync fall, rx_h is not 752 (656 + H_SYNC).
  - err[2]: at a vsync rise, rx_h is not 0 or rx_v is not 490.
  - err[3]: at a vsync fall, rx_v is not 492 or rx_h is not 0.
- Error flags:
  - A set bit stays set until clr_err is asserted or rst is applied.
  - If clr_err is asserted in the same cycle a new error fires, the new bit is set.
- Lock state machine:
  - SEARCH: go to MEASURE on a vsync rise; good counter := 0.
  - MEASURE: any error goes to SEARCH. On a vsync rise with no error in the frame just ended, good counter increments. When the counter reaches LOCK_FRAMES, go to LOCKED; otherwise stay in MEASURE.
  - LOCKED: any error goes to SEARCH and pulses lost_lock for one cycle.
  - frame_count increments on each vsync rise while in LOCKED, including the rise that enters LOCKED.
- Latency: an input sample presented before clock edge k appears on pix_* after edge k+2. pix_x and pix_y are rx_h and rx_v of that sample.
- pix_valid = locked AND rx_h < H_DISPLAY AND rx_v < V_DISPLAY. pix_x, pix_y and pix_rgb update every cycle regardless of pix_valid.
- Probe capture:
  - probe_x and probe_y are latched at each vsync rise.
  - When locked and (rx_h, rx_v) equals the latched probe, probe_rgb := pix_rgb and probe_valid pulses.
  - A probe outside the active area never fires.
- Reset mid-frame: returns to SEARCH. Lock needs one vsync rise plus LOCK_FRAMES clean frames.
- Errors do not stop the counters; the reload rules keep rebuilding coordinates after any error.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the H_* and V_* timing constants, shared with the display controller;
  - the derived sync start and end positions;
  - the error bit index constants;
  - the lock-state enum {SEARCH, MEASURE, LOCKED}.
- One natural sub-module, vga_sync_edge: a 1-bit input register with rise and fall pulse outputs. It is instantiated once for hsync and once for vsync.

Test Plan:
- Drive nominal 800x525 timing from the display controller with rst released at t=0:
  - locked rises at the vsync rise that ends the second clean frame after the first vsync rise;
  - err stays 0;
  - frame_count is 1 at lock and 3 two frames later.
- Nominal stream, with the colour at (100,200) forced to 9'h1C0 and probe=(100,200): after lock, probe_valid pulses once per frame, probe_rgb = 1C0, and pix_x=100, pix_y=200 appear 2 clocks after that pixel's input sample.
- After lock, lengthen one line to 801 clocks: err[0]=1, lost_lock pulses once, locked=0. Relock follows 1 vsync rise plus 2 clean frames. err[0] stays 1 until clr_err.
- After lock, shorten one hsync pulse to 95 clocks: err[1]=1 and lock drops. Assert clr_err in the same cycle as a fresh err[2] event: err[2]=1 and err[1]=0.
- Corrupt vsync width (3 lines), then separately move vsync to line 489: err[3] and err[2] set respectively, and pix_valid is 0 while unlocked.
- Assert rst mid-frame while locked: all outputs are 0 on the next cycle. After release the block relocks in exactly 1 vsync rise plus LOCK_FRAMES frames.
